// File: rtl/seq_arb_4in_requester_pkg.sv
// Shared definitions for the requester front end of the 4-input arbiter.
package seq_arb_pkg;

    localparam int NPORTS = 4;

    typedef logic [1:0] port_idx_t;

    // True when zero or one bit of v is set.
    function automatic logic onehot0(logic [3:0] v);
        return (v & (v - 4'd1)) == 4'd0;
    endfunction

    // Index of the lowest set bit of v (0 when v is zero).
    function automatic port_idx_t lowest_idx(logic [3:0] v);
        port_idx_t idx;
        idx = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_arb_4in_requester_if.sv
// Handshake bundle between producers, the external arbiter, the downstream
// channel and the requester front end.
interface seq_arb_4in_requester_if #(parameter int nbits = 8);
    import seq_arb_pkg::*;

    logic [NPORTS-1:0]       in_val;
    logic [NPORTS-1:0]       in_rdy;
    logic [NPORTS*nbits-1:0] in_msg;
    logic [NPORTS-1:0]       reqs;
    logic [NPORTS-1:0]       grants;
    logic                    out_val;
    logic                    out_rdy;
    logic [nbits-1:0]        out_msg;
    port_idx_t               out_src;
    logic                    err;

    // Front-end side.
    modport slave (
        input  in_val, in_msg, grants, out_rdy,
        output in_rdy, reqs, out_val, out_msg, out_src, err
    );

    // Environment side (producers, arbiter, consumer).
    modport master (
        output in_val, in_msg, grants, out_rdy,
        input  in_rdy, reqs, out_val, out_msg, out_src, err
    );

endinterface

// File: rtl/seq_arb_4in_requester_req_queue.sv
// Two-entry per-port message FIFO. A full queue refuses an enqueue even in
// a cycle where it also dequeues, so enq_rdy depends only on stored state.
module seq_arb_req_queue #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [nbits-1:0] enq_msg,
    input  logic             deq_en,
    output logic [nbits-1:0] head_msg,
    output logic             not_empty
);

    logic [nbits-1:0] mem_q [2];
    logic [nbits-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             enq_fire;
    logic             deq_fire;

    assign enq_rdy   = (count_q != 2'd2);
    assign not_empty = (count_q != 2'd0);
    assign head_msg  = mem_q[rd_ptr_q];
    assign enq_fire  = enq_val && enq_rdy;
    assign deq_fire  = deq_en && not_empty;

    // Next-state: write at wr_ptr, pop at rd_ptr, count saturates at 0..2.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) begin
            mem_d[wr_ptr_q] = enq_msg;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any queued messages.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/seq_arb_4in_requester.sv
// Requester front end: buffers four input streams, raises arbiter requests
// only when downstream can accept, and forwards the granted head message.
module seq_arb_4in_requester
    import seq_arb_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    seq_arb_4in_requester_if.slave  bus
);

    logic [NPORTS-1:0]            enq_rdy;
    logic [NPORTS-1:0]            not_empty;
    logic [NPORTS-1:0]            deq_en;
    logic [NPORTS-1:0]            eff;
    logic [NPORTS-1:0][nbits-1:0] head_msg;
    port_idx_t                    sel;
    logic                         out_val;
    logic [nbits-1:0]             out_msg;
    port_idx_t                    out_src;
    logic                         err_q, err_d;

    for (genvar i = 0; i < NPORTS; i++) begin : g_q
        seq_arb_req_queue #(.nbits(nbits)) u_q (
            .clk       (clk),
            .reset     (reset),
            .enq_val   (bus.in_val[i]),
            .enq_rdy   (enq_rdy[i]),
            .enq_msg   (bus.in_msg[i*nbits +: nbits]),
            .deq_en    (deq_en[i]),
            .head_msg  (head_msg[i]),
            .not_empty (not_empty[i])
        );
    end

    // Requests are gated by out_rdy so the arbiter never rotates on a grant
    // that cannot be consumed; everything is held low while in reset.
    assign bus.in_rdy = enq_rdy & {NPORTS{reset}};
    assign bus.reqs   = not_empty & {NPORTS{bus.out_rdy & reset}};
    assign eff        = bus.grants & bus.reqs;
    assign sel        = lowest_idx(eff);

    // Output mux and dequeue decode: only the selected port pops, so stray
    // grant bits never drain a queue.
    always_comb begin
        out_val = |eff;
        out_msg = '0;
        out_src = '0;
        deq_en  = '0;
        if (out_val) begin
            out_msg     = head_msg[sel];
            out_src     = sel;
            deq_en[sel] = 1'b1;
        end
    end

    assign bus.out_val = out_val;
    assign bus.out_msg = out_msg;
    assign bus.out_src = out_src;

    // Sticky protocol error on multi-hot grants or grants without a request.
    always_comb begin
        err_d = err_q | ~onehot0(bus.grants) | (|(bus.grants & ~bus.reqs));
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q & reset;

endmodule

// File: tb/tb_seq_arb_4in_requester.sv
// Bench for the requester front end: a rotating-priority arbiter in the
// environment, a queue-based reference model, directed scenarios then random.
module tb_seq_arb_4in_requester;
    import seq_arb_pkg::*;

    localparam int NB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic direct = 1'b0;
    logic [3:0] direct_g = 4'd0;
    logic [3:0] arb_g;
    logic [1:0] arb_p;
    logic [1:0] arb_idx;

    int checks = 0;
    int failures = 0;

    seq_arb_4in_requester_if #(.nbits(NB)) bus();

    seq_arb_4in_requester #(.nbits(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Rotating-priority arbiter: arb_p is the highest-priority port.
    always_comb begin
        arb_g   = 4'd0;
        arb_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            arb_idx = arb_p + 2'(k);
            if (arb_g == 4'd0 && bus.reqs[arb_idx]) arb_g[arb_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) arb_p <= 2'd0;
        else begin
            for (int k = 0; k < 4; k++) if (arb_g[k]) arb_p <= 2'(k + 1);
        end
    end

    assign bus.grants = direct ? direct_g : arb_g;

    // Reference model state.
    logic [7:0] mq [4][$];
    int   mprio = 0;
    bit   merr = 1'b0;
    logic [3:0] m_er, m_eg, m_ag;
    int   m_sel, m_agi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Settle, then compare all outputs against the model for this cycle.
    task automatic check_now();
        logic [3:0] erdy, eff;
        logic [7:0] emsg;
        int idx;
        #2;
        for (int i = 0; i < 4; i++) begin
            erdy[i] = reset && (mq[i].size() < 2);
            m_er[i] = reset && (mq[i].size() != 0) && bus.out_rdy;
        end
        m_ag = 4'd0; m_agi = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (mprio + k) % 4;
            if (m_agi < 0 && m_er[idx]) begin m_ag[idx] = 1'b1; m_agi = idx; end
        end
        m_eg = direct ? direct_g : m_ag;
        eff = m_eg & m_er;
        m_sel = -1;
        for (int i = 3; i >= 0; i--) if (eff[i]) m_sel = i;
        emsg = (m_sel >= 0) ? mq[m_sel][0] : 8'h00;
        chk("in_rdy",  32'(bus.in_rdy),  32'(erdy));
        chk("reqs",    32'(bus.reqs),    32'(m_er));
        chk("out_val", 32'(bus.out_val), 32'(m_sel >= 0));
        chk("out_msg", 32'(bus.out_msg), 32'(emsg));
        chk("out_src", 32'(bus.out_src), (m_sel >= 0) ? 32'(m_sel) : 32'd0);
        chk("err",     32'(bus.err),     32'(reset && merr));
    endtask

    // Take the clock edge and apply the same rules to the model.
    task automatic advance();
        bit acc [4];
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            mprio = 0;
            merr  = 1'b0;
        end else begin
            if ($countones(m_eg) > 1 || (m_eg & ~m_er) != 4'd0) merr = 1'b1;
            for (int i = 0; i < 4; i++) acc[i] = bus.in_val[i] && (mq[i].size() < 2);
            if (m_sel >= 0) void'(mq[m_sel].pop_front());
            for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(bus.in_msg[i*NB +: NB]);
            if (m_agi >= 0) mprio = (m_agi + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic step();
        check_now();
        advance();
    endtask

    task automatic do_reset(input int n, input bit rnd_in);
        reset = 1'b0;
        for (int c = 0; c < n; c++) begin
            bus.in_val = rnd_in ? 4'($urandom) : 4'd0;
            bus.in_msg = 32'($urandom);
            step();
        end
        reset = 1'b1;
        bus.in_val = 4'd0;
    endtask

    // Preload two messages per port: 0x10*i then 0x10*i+1.
    task automatic load_all();
        bus.out_rdy = 1'b0;
        for (int e = 0; e < 2; e++) begin
            bus.in_val = 4'hF;
            for (int i = 0; i < 4; i++) bus.in_msg[i*NB +: NB] = 8'(16 * i + e);
            step();
        end
        bus.in_val = 4'd0;
    endtask

    logic [7:0] order [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};

    initial begin
        bus.in_val = 4'd0;
        bus.in_msg = '0;
        bus.out_rdy = 1'b0;
        @(negedge clk);

        // Reset hold with activity on the inputs: everything stays low.
        do_reset(3, 1'b1);

        // First cycle after reset.
        check_now();
        chk("post_reset_in_rdy", 32'(bus.in_rdy), 32'hF);
        chk("post_reset_out_val", 32'(bus.out_val), 32'd0);
        advance();

        // Single port: 0xA5 on port 2, one cycle latency.
        bus.out_rdy = 1'b1;
        bus.in_val = 4'b0100;
        bus.in_msg[2*NB +: NB] = 8'hA5;
        step();
        bus.in_val = 4'd0;
        check_now();
        chk("single_reqs", 32'(bus.reqs), 32'b0100);
        chk("single_msg", 32'(bus.out_msg), 32'hA5);
        chk("single_src", 32'(bus.out_src), 32'd2);
        advance();
        check_now();
        chk("single_drained", 32'(bus.out_val), 32'd0);
        advance();

        // All full, then drain in rotating order.
        do_reset(2, 1'b0);
        load_all();
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_now();
            chk("full_order", 32'(bus.out_msg), 32'(order[k]));
            advance();
        end
        step();

        // Backpressure: nothing requested or rotated, then same order.
        do_reset(2, 1'b0);
        load_all();
        for (int c = 0; c < 3; c++) begin
            check_now();
            chk("bp_reqs", 32'(bus.reqs), 32'd0);
            chk("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
            advance();
        end
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_now();
            chk("bp_order", 32'(bus.out_msg), 32'(order[k]));
            advance();
        end

        // Full queue: third back-to-back enqueue on port 1 is refused.
        do_reset(2, 1'b0);
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_val = 4'b0010;
            bus.in_msg[NB +: NB] = 8'(8'h41 + c);
            check_now();
            if (c == 2) chk("fullq_in_rdy1", 32'(bus.in_rdy[1]), 32'd0);
            advance();
        end
        bus.in_val = 4'd0;
        bus.out_rdy = 1'b1;
        check_now(); chk("fullq_first", 32'(bus.out_msg), 32'h41); advance();
        check_now(); chk("fullq_second", 32'(bus.out_msg), 32'h42); advance();
        check_now(); chk("fullq_empty", 32'(bus.out_val), 32'd0); advance();

        // Reset mid-stream: queued data must never reappear.
        do_reset(2, 1'b0);
        load_all();
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) step();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.in_val = 4'($urandom);
            check_now();
            chk("midrst_out_val", 32'(bus.out_val), 32'd0);
            chk("midrst_in_rdy", 32'(bus.in_rdy), 32'd0);
            advance();
        end
        reset = 1'b1;
        bus.in_val = 4'd0;
        for (int c = 0; c < 3; c++) begin
            check_now();
            chk("midrst_after_rdy", 32'(bus.in_rdy), 32'hF);
            chk("midrst_no_stale", 32'(bus.out_val), 32'd0);
            advance();
        end

        // Protocol error: two grant bits; only port 0 dequeues.
        do_reset(2, 1'b0);
        bus.out_rdy = 1'b0;
        bus.in_val = 4'b0011;
        bus.in_msg[0 +: NB] = 8'h50;
        bus.in_msg[NB +: NB] = 8'h51;
        step();
        bus.in_val = 4'd0;
        bus.out_rdy = 1'b1;
        direct = 1'b1;
        direct_g = 4'b0011;
        check_now(); chk("perr_before", 32'(bus.err), 32'd0); advance();
        direct_g = 4'd0;
        check_now();
        chk("perr_set", 32'(bus.err), 32'd1);
        chk("perr_port1_kept", 32'(bus.reqs), 32'b0010);
        advance();
        direct = 1'b0;
        check_now();
        chk("perr_sticky", 32'(bus.err), 32'd1);
        chk("perr_port1_msg", 32'(bus.out_msg), 32'h51);
        advance();

        // Protocol error: grant without request; no dequeue.
        do_reset(2, 1'b0);
        bus.out_rdy = 1'b0;
        bus.in_val = 4'b0001;
        bus.in_msg[0 +: NB] = 8'h60;
        step();
        bus.in_val = 4'd0;
        bus.out_rdy = 1'b1;
        direct = 1'b1;
        direct_g = 4'b1000;
        step();
        direct_g = 4'd0;
        check_now();
        chk("perr2_set", 32'(bus.err), 32'd1);
        chk("perr2_no_deq", 32'(bus.reqs), 32'b0001);
        advance();
        direct = 1'b0;
        step();

        // Random traffic against the model.
        do_reset(2, 1'b0);
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 99) >= 2);
            bus.in_val  = 4'($urandom);
            bus.in_msg  = 32'($urandom);
            bus.out_rdy = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_arb_4in_requester.md
# seq_arb_4in_requester

Requester-side front end for the 4-input rotating-priority arbiter. It buffers messages from four val/rdy input streams in per-port 2-entry queues and drives the arbiter's `reqs` vector. It consumes the arbiter's one-hot `grants` in the same cycle and forwards the granted head-of-queue message onto a single val/rdy output stream. It sits between four producers and a shared downstream channel, with the arbiter external.

## Interface
- `nbits`, default 8: message width per port.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low; state clears on a rising edge with `reset==0`.
- `in_val` in 4: per-port input valid.
- `in_rdy` out 4: per-port input ready.
- `in_msg` in 4*nbits: port i message at bits [i*nbits +: nbits].
- `reqs` out 4: request vector to the arbiter.
- `grants` in 4: grant vector from the arbiter, combinational from `reqs` in the same cycle.
- `out_val` out 1: forwarded message valid.
- `out_rdy` in 1: downstream ready.
- `out_msg` out nbits: forwarded message.
- `out_src` out 2: index of the port that supplied `out_msg`.
- `err` out 1: sticky protocol-error flag.

## Operation
- Each port has a 2-entry FIFO with 1-bit read/write pointers and a 2-bit count (0..2). The count never wraps past 2.
- `in_rdy[i] = (count[i] != 2)`.
  - It depends only on registered state; there is no combinational path from `out_rdy` or `grants`.
  - A full queue refuses an enqueue even in a cycle where it dequeues.
- Enqueue on port i when `in_val[i] && in_rdy[i]`. The message is written at the write pointer on the clock edge.
- No bypass: an empty queue enqueued in cycle N first requests in cycle N+1.
- `reqs[i] = (count[i] != 0) && out_rdy`. Requests are gated by `out_rdy` so the arbiter's priority never rotates on a grant that cannot be consumed.
- Let `eff = grants & reqs`.
  - `out_val = (eff != 0)`.
  - `out_msg` is the head entry of the lowest-indexed set bit of `eff`.
  - `out_src` is that bit's index.
  - When `out_val==0`, `out_msg` and `out_src` are 0.
- Dequeue port i on the clock edge iff it is the port selected for output (`out_val && out_rdy` always holds when selected). Only that port dequeues, so at most one dequeue per cycle.
- Simultaneous enqueue and dequeue on the same port (count 1) leaves count at 1 and advances both pointers.
- `err` is set on any edge where `grants` has more than one bit set, or `grants & ~reqs != 0`. It stays set until reset.
  - Extra or illegal grant bits never cause a dequeue.
- Reset (`reset==0` on an edge) empties all queues, zeroes pointers, and clears `err`. This holds mid-operation: queued messages are discarded.

## Timing
- While `reset==0`:
  - `in_rdy`, `reqs`, `out_val`, `err` = 0.
  - Inputs are ignored.
  - `grants` is not checked, so `err` is not set.
- First cycle after reset: `in_rdy=4'b1111`, `reqs=0`, `out_val=0`, `err=0`.
- Minimum input-to-output latency is 1 cycle. A message enqueued in cycle N can appear on `out_msg` in cycle N+1.
- Throughput: one output message per cycle when any queue is non-empty and `out_rdy=1`.
- Each port sustains one enqueue per cycle only while draining; otherwise it holds 2 messages then stalls.
- `reqs`, `out_val`, `out_msg`, `out_src` are combinational within the cycle. `in_rdy` and `err` are registered.

## Structure
- Shared package `seq_arb_pkg` holds:
  - `NPORTS=4`.
  - `port_idx_t` (2-bit).
  - Function `onehot0(logic [3:0])`, true for zero or one bit set.
  - Function `lowest_idx(logic [3:0])`.
- Sub-module `seq_arb_req_queue` (parameter `nbits`): 2-entry FIFO with `enq_val`, `enq_rdy`, `enq_msg`, `deq_en`, `head_msg`, `not_empty`. Instantiated four times.
- The top level holds the request gating, output mux, dequeue decode and `err` register.

## Test plan
The bench connects the block to the rotating arbiter, which has port 0 highest priority after reset and makes the granted port lowest priority after each grant, except in the last scenario, which drives `grants` directly.
- Single port: enqueue 0xA5 on port 2 at cycle 0 with `out_rdy=1` -> cycle 1 `reqs=4'b0100`, `out_val=1`, `out_msg=0xA5`, `out_src=2`; cycle 2 `out_val=0`.
- All full: preload 2 messages per port (port i carries 0x10*i, 0x10*i+1), then `out_rdy=1` -> outputs 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31 on consecutive cycles; `in_rdy` returns to 1 per port after its first dequeue.
- Backpressure: all queues loaded, `out_rdy=0` for 3 cycles -> `reqs=0`, `out_val=0`, `in_rdy=0000`, no arbiter rotation; release -> same order as the all-full scenario.
- Full queue: 3 back-to-back `in_val` on port 1 with `out_rdy=0` -> third enqueue refused (`in_rdy[1]=0`), count stays 2.
- Reset mid-stream: hold `reset=0` for 2 cycles with queues half-drained -> all outputs 0 during reset, `in_rdy=1111` after, and no stale message ever appears on `out_msg`.
- Protocol error (bench drives `grants` directly instead of the arbiter): drive `grants=4'b0011` with `reqs=4'b0011` -> `err=1` next cycle and stays 1; only port 0 dequeues that cycle. `grants=4'b1000` with `reqs[3]=0` also sets `err`.
